// File: rtl/vga_timing.sv
// Pixel-timing generator: hpos/vpos counters, registered syncs, visible flag and frame strobes.
// Optional macro VGA_TIMING_SYNC_DELAY_EN adds one pix_en-gated register stage to both syncs.
module vga_timing #(
    parameter int unsigned H_VIEW     = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VIEW     = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned FRAME_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pix_en,
    output logic [9:0]            hpos,
    output logic [9:0]            vpos,
    output logic                  hsync_n,
    output logic                  vsync_n,
    output logic                  visible,
    output logic                  hmax,
    output logic                  vmax,
    output logic                  frame_end,
    output logic                  field,
    output logic [FRAME_BITS-1:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VIEW + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VIEW + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024) begin : g_h_total_too_big
        $error("H_TOTAL does not fit the 10-bit horizontal counter");
    end
    if (V_TOTAL > 1024) begin : g_v_total_too_big
        $error("V_TOTAL does not fit the 10-bit vertical counter");
    end

    localparam logic [9:0]  HLast      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  VLast      = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync pulse ending exactly at 1024 still compares correctly
    localparam logic [10:0] HView      = 11'(H_VIEW);
    localparam logic [10:0] VView      = 11'(V_VIEW);
    localparam logic [10:0] HSyncStart = 11'(H_VIEW + H_FRONT);
    localparam logic [10:0] HSyncEnd   = 11'(H_VIEW + H_FRONT + H_SYNC);
    localparam logic [10:0] VSyncStart = 11'(V_VIEW + V_FRONT);
    localparam logic [10:0] VSyncEnd   = 11'(V_VIEW + V_FRONT + V_SYNC);
    localparam logic [FRAME_BITS-1:0] FrameOne = FRAME_BITS'(1);

    logic [9:0]            h_q, h_d, v_q, v_d;
    logic                  frame_wrap;
    logic                  hsync_q, hsync_d, vsync_q, vsync_d;
    logic                  vis_q, vis_d, hmax_q, hmax_d, vmax_q, vmax_d, fend_q;
    logic                  field_q;
    logic [FRAME_BITS-1:0] fcount_q;

    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        frame_wrap = 1'b0;
        if (h_q == HLast) begin
            h_d = '0;
            if (v_q == VLast) begin
                v_d        = '0;
                frame_wrap = 1'b1;
            end else begin
                v_d = v_q + 10'd1;
            end
        end else begin
            h_d = h_q + 10'd1;
        end
    end

    // Decodes use next-state counters so registered outputs line up with hpos/vpos
    always_comb begin
        hsync_d = !(({1'b0, h_d} >= HSyncStart) && ({1'b0, h_d} < HSyncEnd));
        vsync_d = !(({1'b0, v_d} >= VSyncStart) && ({1'b0, v_d} < VSyncEnd));
        vis_d   = ({1'b0, h_d} < HView) && ({1'b0, v_d} < VView);
        hmax_d  = (h_d == HLast);
        vmax_d  = (v_d == VLast);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            vis_q    <= 1'b1;
            hmax_q   <= 1'b0;
            vmax_q   <= 1'b0;
            fend_q   <= 1'b0;
            field_q  <= 1'b0;
            fcount_q <= '0;
        end else if (pix_en) begin
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            vis_q   <= vis_d;
            hmax_q  <= hmax_d;
            vmax_q  <= vmax_d;
            fend_q  <= hmax_d & vmax_d;
            if (frame_wrap) begin
                field_q  <= ~field_q;
                fcount_q <= fcount_q + FrameOne;
            end
        end
    end

`ifdef VGA_TIMING_SYNC_DELAY_EN
    logic hsync_dly_q, vsync_dly_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_dly_q <= 1'b1;
            vsync_dly_q <= 1'b1;
        end else if (pix_en) begin
            hsync_dly_q <= hsync_q;
            vsync_dly_q <= vsync_q;
        end
    end

    assign hsync_n = hsync_dly_q;
    assign vsync_n = vsync_dly_q;
`else
    assign hsync_n = hsync_q;
    assign vsync_n = vsync_q;
`endif

    assign hpos        = h_q;
    assign vpos        = v_q;
    assign visible     = vis_q;
    assign hmax        = hmax_q;
    assign vmax        = vmax_q;
    assign frame_end   = fend_q;
    assign field       = field_q;
    assign frame_count = fcount_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 640x480 instance and a tiny-timing instance share one stimulus,
// each checked cycle by cycle against a scoreboard fed from a bench-side timing model.
module tb_vga_timing;

    logic clk = 1'b0;
    logic reset_n;
    logic pix_en;

    always #5 clk = ~clk;

    logic [9:0] h0, v0, h1, v1;
    logic       hs0, vs0, vis0, hm0, vm0, fe0, fld0;
    logic       hs1, vs1, vis1, hm1, vm1, fe1, fld1;
    logic [7:0] fc0, fc1;

    vga_timing u_dut0 (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .hpos(h0), .vpos(v0), .hsync_n(hs0), .vsync_n(vs0), .visible(vis0),
        .hmax(hm0), .vmax(vm0), .frame_end(fe0), .field(fld0), .frame_count(fc0)
    );

    vga_timing #(
        .H_VIEW(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VIEW(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1), .FRAME_BITS(8)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .hpos(h1), .vpos(v1), .hsync_n(hs1), .vsync_n(vs1), .visible(vis1),
        .hmax(hm1), .vmax(vm1), .frame_end(fe1), .field(fld1), .frame_count(fc1)
    );

    wire [34:0] act0 = {h0, v0, hs0, vs0, vis0, hm0, vm0, fe0, fld0, fc0};
    wire [34:0] act1 = {h1, v1, hs1, vs1, vis1, hm1, vm1, fe1, fld1, fc1};

    // Hand-derived timing of each instance: totals, visible sizes, sync windows [start, end)
    int ht[2]    = '{800, 15};
    int vt[2]    = '{525, 11};
    int hview[2] = '{640, 8};
    int vview[2] = '{480, 6};
    int hss[2]   = '{656, 10};
    int hse[2]   = '{752, 13};
    int vss[2]   = '{490, 8};
    int vse[2]   = '{492, 10};

    int         mh[2], mv[2];
    logic       mfield[2], mhsd[2], mvsd[2];
    logic [7:0] mfc[2];

    typedef struct {
        int         k;
        logic [34:0] v;
    } sb_t;
    sb_t sbq[$];

    int total = 0;
    int bad   = 0;
    logic [34:0] rst_v;

    function automatic logic [34:0] act(input int k);
        return (k == 0) ? act0 : act1;
    endfunction

    function automatic string show(input logic [34:0] x);
        return $sformatf("h=%0d v=%0d hs=%b vs=%b vis=%b hm=%b vm=%b fe=%b fld=%b fc=%0d",
                         x[34:25], x[24:15], x[14], x[13], x[12], x[11], x[10], x[9], x[8],
                         x[7:0]);
    endfunction

    function automatic logic aligned_hs(input int k);
        return !(mh[k] >= hss[k] && mh[k] < hse[k]);
    endfunction

    function automatic logic aligned_vs(input int k);
        return !(mv[k] >= vss[k] && mv[k] < vse[k]);
    endfunction

    function automatic logic [34:0] calc(input int k);
        logic hs, vs, vis, hm, vm;
        hs  = aligned_hs(k);
        vs  = aligned_vs(k);
`ifdef VGA_TIMING_SYNC_DELAY_EN
        hs  = mhsd[k];
        vs  = mvsd[k];
`endif
        vis = (mh[k] < hview[k]) && (mv[k] < vview[k]);
        hm  = (mh[k] == ht[k] - 1);
        vm  = (mv[k] == vt[k] - 1);
        return {10'(mh[k]), 10'(mv[k]), hs, vs, vis, hm, vm, hm & vm, mfield[k], mfc[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mh[k] = 0; mv[k] = 0; mfield[k] = 1'b0; mfc[k] = 8'd0;
            mhsd[k] = 1'b1; mvsd[k] = 1'b1;
        end
    endtask

    task automatic model_adv(input int k);
        logic ohs, ovs;
        ohs = aligned_hs(k);
        ovs = aligned_vs(k);
        if (mh[k] == ht[k] - 1) begin
            mh[k] = 0;
            if (mv[k] == vt[k] - 1) begin
                mv[k]     = 0;
                mfield[k] = ~mfield[k];
                mfc[k]    = mfc[k] + 8'd1;
            end else begin
                mv[k] = mv[k] + 1;
            end
        end else begin
            mh[k] = mh[k] + 1;
        end
        mhsd[k] = ohs;
        mvsd[k] = ovs;
    endtask

    // One clock: push expectations for both instances, then drain and compare after the edge
    task automatic tick(input logic en);
        sb_t e;
        pix_en = en;
        for (int k = 0; k < 2; k++) begin
            if (en) model_adv(k);
            e.k = k;
            e.v = calc(k);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            total++;
            if (act(e.k) !== e.v) begin
                bad++;
                $display("FAIL scoreboard dut%0d t=%0t got {%s} want {%s}", e.k, $time,
                         show(act(e.k)), show(e.v));
            end
        end
    endtask

    task automatic test_reset();
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (act0 !== rst_v) begin
            bad++;
            $display("FAIL reset_dut0 got {%s} want {%s}", show(act0), show(rst_v));
        end
        total++;
        if (act1 !== rst_v) begin
            bad++;
            $display("FAIL reset_dut1 got {%s} want {%s}", show(act1), show(rst_v));
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_line();
        int low_cnt = 0, first_low = -1, hm_cnt = 0, hm_pos = -1, want_first;
        for (int i = 0; i < 800; i++) begin
            tick(1'b1);
            if (!hs0) begin
                low_cnt++;
                if (first_low < 0) first_low = int'(h0);
            end
            if (hm0) begin
                hm_cnt++;
                hm_pos = int'(h0);
            end
        end
`ifdef VGA_TIMING_SYNC_DELAY_EN
        want_first = 657;
`else
        want_first = 656;
`endif
        total++;
        if (low_cnt != 96) begin
            bad++; $display("FAIL hsync_width got %0d want 96", low_cnt);
        end
        total++;
        if (first_low != want_first) begin
            bad++; $display("FAIL hsync_start got %0d want %0d", first_low, want_first);
        end
        total++;
        if (hm_cnt != 1 || hm_pos != 799) begin
            bad++; $display("FAIL hmax got count=%0d pos=%0d want count=1 pos=799", hm_cnt, hm_pos);
        end
        total++;
        if (h0 !== 10'd0 || v0 !== 10'd1) begin
            bad++; $display("FAIL line_wrap got (%0d,%0d) want (0,1)", h0, v0);
        end
    endtask

    task automatic test_pix_en();
        logic       pat[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [9:0] want[4] = '{10'd11, 10'd11, 10'd12, 10'd12};
        for (int i = 0; i < 10; i++) tick(1'b1);
        total++;
        if (h0 !== 10'd10) begin
            bad++; $display("FAIL pix_en_start got %0d want 10", h0);
        end
        for (int i = 0; i < 4; i++) begin
            tick(pat[i]);
            total++;
            if (h0 !== want[i]) begin
                bad++; $display("FAIL pix_en_seq[%0d] got %0d want %0d", i, h0, want[i]);
            end
        end
    endtask

    task automatic test_frame();
        int vs_low = 0, fe_cnt = 0;
        for (int i = 0; i < 400 && !fe1; i++) tick(1'b1);
        total++;
        if (fe1 !== 1'b1 || h1 !== 10'd14 || v1 !== 10'd10) begin
            bad++; $display("FAIL frame_end_pos got fe=%b (%0d,%0d) want fe=1 (14,10)", fe1, h1, v1);
        end
        for (int i = 0; i < 165; i++) begin
            tick(1'b1);
            if (!vs1) vs_low++;
            if (fe1) fe_cnt++;
        end
        total++;
        if (vs_low != 30) begin
            bad++; $display("FAIL vsync_width got %0d want 30", vs_low);
        end
        total++;
        if (fe_cnt != 1 || fe1 !== 1'b1) begin
            bad++; $display("FAIL frame_end_once got count=%0d last=%b want count=1 last=1",
                            fe_cnt, fe1);
        end
        tick(1'b1);
        total++;
        if (fe1 !== 1'b0 || hm1 !== 1'b0 || vm1 !== 1'b0 || h1 !== 10'd0 || v1 !== 10'd0) begin
            bad++; $display("FAIL frame_wrap got fe=%b hm=%b vm=%b (%0d,%0d) want 0 0 0 (0,0)",
                            fe1, hm1, vm1, h1, v1);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 200 && !(h1 == 10'd12 && v1 == 10'd9); i++) tick(1'b1);
        total++;
        if (h1 !== 10'd12 || v1 !== 10'd9) begin
            bad++; $display("FAIL reset_target got (%0d,%0d) want (12,9)", h1, v1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (act0 !== rst_v) begin
            bad++; $display("FAIL async_reset_dut0 got {%s} want {%s}", show(act0), show(rst_v));
        end
        total++;
        if (act1 !== rst_v) begin
            bad++; $display("FAIL async_reset_dut1 got {%s} want {%s}", show(act1), show(rst_v));
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick(1'b1);
        total++;
        if (h1 !== 10'd1 || v1 !== 10'd0 || vs1 !== 1'b1 || h0 !== 10'd1 || v0 !== 10'd0) begin
            bad++; $display("FAIL restart got dut1 (%0d,%0d) vs=%b dut0 (%0d,%0d) want (1,0) 1 (1,0)",
                            h1, v1, vs1, h0, v0);
        end
    endtask

    task automatic test_frame_count_wrap();
        for (int i = 0; i < 255 * 165; i++) tick(1'b1);
        total++;
        if (fc1 !== 8'd255 || fld1 !== 1'b1) begin
            bad++; $display("FAIL frames_255 got fc=%0d field=%b want fc=255 field=1", fc1, fld1);
        end
        for (int i = 0; i < 165; i++) tick(1'b1);
        total++;
        if (fc1 !== 8'd0 || fld1 !== 1'b0) begin
            bad++; $display("FAIL frames_256 got fc=%0d field=%b want fc=0 field=0", fc1, fld1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_v   = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        reset_n = 1'b0;
        pix_en  = 1'b0;
        model_reset();
        #12;
        test_reset();
        test_line();
        test_pix_en();
        test_frame();
        test_async_reset();
        test_frame_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
